disp_sel_ctrl: RTL and testbench
================================

# disp_sel_ctrl

Display-side selection controller for the vending-machine LCD front panel. It tracks the goods cursor and the confirmed selection, and runs frame-based blink and coin-flash timers. Each cycle it compares the registered area code from the pixel area classifier against these, producing highlight strobes for the colour mux. It sits between the key/coin input conditioning and the pixel colour generator, sharing the single highlight colour path among cursor, selection and coin feedback.

## Interface
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 480, active lines per frame
- N_GOODS, 12, number of goods blocks (cursor range 0..N_GOODS-1)
- BLINK_FRAMES, 30, frames per blink half-period
- FLASH_FRAMES, 20, frames a coin button stays highlighted after a coin pulse
- clk  in  1  pixel clock
- rstn  in  1  reset, asynchronous, active-low
- pixel_xpos  in  11  current pixel x from LCD driver
- pixel_ypos  in  11  current pixel y from LCD driver
- pix_area  in  6  registered area code from classifier (25..36 goods blocks, 1..12 prices, 45..47 coin frames)
- key_left, key_right, key_ok, key_cancel  in  1 each  debounced single-cycle pulses
- coin_pulse  in  3  single-cycle pulses: bit0 0.5 yuan, bit1 1 yuan, bit2 5 yuan
- vend_busy  in  1  level, vend mechanism active
- cursor  out  4  current cursor index
- sel_valid  out  1  high while a selection is confirmed (CONFIRM or LOCKED)
- sel_idx  out  4  confirmed goods index, valid with sel_valid
- frame_tick  out  1  one-cycle frame strobe
- hl_block  out  1  highlight current pixel as cursor/selected goods block
- hl_price  out  1  highlight current pixel as selected price tag
- hl_coin  out  1  highlight current pixel as flashing coin frame

## Operation
- frame_tick: asserted for exactly one cycle on the first cycle where pixel_xpos==H_ACTIVE-1 and pixel_ypos==V_ACTIVE-1 (rising-edge detect of the match; a held coordinate gives one tick).
- FSM states BROWSE, CONFIRM, LOCKED; reset state BROWSE.
- BROWSE: key_right increments cursor, N_GOODS-1 wraps to 0; key_left decrements, 0 wraps to N_GOODS-1. Left and right in the same cycle: no move. key_ok -> CONFIRM, sel_idx<=cursor. A move takes priority over ok in the same cycle only if ok is absent; ok with a move: move ignored, ok taken with the pre-move cursor.
- CONFIRM: cursor frozen; key_cancel -> BROWSE, sel_valid drops. ok and cancel in the same cycle: cancel wins. vend_busy high (and no cancel that cycle) -> LOCKED.
- LOCKED: all keys ignored; on vend_busy low -> BROWSE, sel_valid cleared.
- Blink: frame counter 0..BLINK_FRAMES-1 advances on frame_tick; blink_on toggles at wrap. Any cursor move resets counter to 0 and blink_on to 1.
- Coin flash: three independent counters. coin_pulse[i] loads FLASH_FRAMES (re-load on repeat, even if nonzero). Decrement on frame_tick when nonzero. Load wins over a same-cycle decrement. Works in all states.
- hl_block = (pix_area==25+cursor) && (blink_on || state!=BROWSE).
- hl_price = sel_valid && (pix_area==1+sel_idx).
- hl_coin = (pix_area==45+i) && flash_cnt[i]!=0, for i=0..2.
- Area codes outside these ranges produce no highlight.

## Timing
- Reset values: cursor 0, sel_idx 0, sel_valid 0, frame_tick 0, hl_* 0, blink_on 1, blink and flash counters 0.
- hl_* are registered: one-cycle latency from pix_area, two from pixel coordinates.
- Key, FSM and cursor updates take effect the cycle after the pulse. hl_block reflects a new cursor on the following pix_area compare, so no mid-pixel glitch.
- sel_valid rises the cycle after key_ok and falls the cycle after cancel or vend_busy falls in LOCKED.
- rstn assertion mid-frame clears all state immediately. The first frame_tick after release requires a fresh coordinate match.

## Test plan
- Reset, then 13 key_right pulses -> cursor 0,1,…,11,0,1. One key_left from 0 -> 11.
- Cursor 3, drive pix_area 28 for 2×BLINK_FRAMES frames -> hl_block toggles every 30 frame_ticks. pix_area 27 -> hl_block 0.
- Cursor 5, key_ok -> sel_valid 1, sel_idx 5. pix_area 6 -> hl_price 1. pix_area 30 -> hl_block steady 1. key_ok and key_cancel together -> BROWSE, sel_valid 0.
- CONFIRM, vend_busy 1 -> LOCKED. key_right ignored, cursor unchanged. vend_busy 0 -> BROWSE, sel_valid 0.
- coin_pulse=3'b100, pix_area 47 -> hl_coin 1 for exactly 20 frame_ticks, then 0. Second pulse at tick 10 -> extends to 30 total.
- Hold coordinates at (799,479) for 5 cycles -> single frame_tick. Assert rstn low mid-blink -> all outputs 0 and blink_on 1 next cycle.

Source files
------------

// File: rtl/disp_sel_ctrl.sv
// rtl/disp_sel_ctrl.sv - LCD goods cursor/selection tracker with blink and coin-flash highlight strobes
module disp_sel_ctrl #(
    parameter int H_ACTIVE     = 800,
    parameter int V_ACTIVE     = 480,
    parameter int N_GOODS      = 12,
    parameter int BLINK_FRAMES = 30,
    parameter int FLASH_FRAMES = 20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    input  logic [5:0]  pix_area,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_ok,
    input  logic        key_cancel,
    input  logic [2:0]  coin_pulse,
    input  logic        vend_busy,
    output logic [3:0]  cursor,
    output logic        sel_valid,
    output logic [3:0]  sel_idx,
    output logic        frame_tick,
    output logic        hl_block,
    output logic        hl_price,
    output logic        hl_coin
);

    localparam int BW = $clog2(BLINK_FRAMES);
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    typedef enum logic [1:0] {BROWSE, CONFIRM, LOCKED} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cursor_q, cursor_d;
    logic [3:0]     sel_idx_q, sel_idx_d;
    logic           match_q, match_d;
    logic           frame_tick_q, frame_tick_d;
    logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
    logic           blink_on_q, blink_on_d;
    logic [FW-1:0]  flash_q [3];
    logic [FW-1:0]  flash_d [3];
    logic           hl_block_q, hl_block_d;
    logic           hl_price_q, hl_price_d;
    logic           hl_coin_q, hl_coin_d;
    logic           moved;
    logic           mv_r, mv_l;

    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        sel_idx_d    = sel_idx_q;
        blink_cnt_d  = blink_cnt_q;
        blink_on_d   = blink_on_q;
        flash_d      = flash_q;
        moved        = 1'b0;
        hl_coin_d    = 1'b0;
        mv_r         = key_right & ~key_left;
        mv_l         = key_left & ~key_right;

        match_d      = (pixel_xpos == 11'(H_ACTIVE - 1)) && (pixel_ypos == 11'(V_ACTIVE - 1));
        frame_tick_d = match_d & ~match_q;

        // ok outranks a same-cycle move so the selection uses the pre-move cursor
        case (state_q)
            BROWSE: begin
                if (key_ok) begin
                    state_d   = CONFIRM;
                    sel_idx_d = cursor_q;
                end else if (mv_r) begin
                    cursor_d = (cursor_q == 4'(N_GOODS - 1)) ? 4'd0 : cursor_q + 4'd1;
                    moved    = 1'b1;
                end else if (mv_l) begin
                    cursor_d = (cursor_q == 4'd0) ? 4'(N_GOODS - 1) : cursor_q - 4'd1;
                    moved    = 1'b1;
                end
            end
            CONFIRM: begin
                if (key_cancel)     state_d = BROWSE;
                else if (vend_busy) state_d = LOCKED;
            end
            LOCKED: begin
                if (!vend_busy) state_d = BROWSE;
            end
            default: state_d = BROWSE;
        endcase

        if (moved) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (frame_tick_q) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        for (int i = 0; i < 3; i++) begin
            if (coin_pulse[i])
                flash_d[i] = FW'(FLASH_FRAMES);
            else if (frame_tick_q && flash_q[i] != '0)
                flash_d[i] = flash_q[i] - FW'(1);
            if (pix_area == 6'(45 + i) && flash_q[i] != '0)
                hl_coin_d = 1'b1;
        end

        hl_block_d = (pix_area == 6'd25 + {2'b00, cursor_q}) && (blink_on_q || state_q != BROWSE);
        hl_price_d = (state_q != BROWSE) && (pix_area == 6'd1 + {2'b00, sel_idx_q});
    end

    // match_q resets high so a coordinate held through reset needs a fresh match
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= BROWSE;
            cursor_q     <= '0;
            sel_idx_q    <= '0;
            match_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            flash_q      <= '{default: '0};
            hl_block_q   <= 1'b0;
            hl_price_q   <= 1'b0;
            hl_coin_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            sel_idx_q    <= sel_idx_d;
            match_q      <= match_d;
            frame_tick_q <= frame_tick_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            flash_q      <= flash_d;
            hl_block_q   <= hl_block_d;
            hl_price_q   <= hl_price_d;
            hl_coin_q    <= hl_coin_d;
        end
    end

    assign cursor     = cursor_q;
    assign sel_valid  = (state_q != BROWSE);
    assign sel_idx    = sel_idx_q;
    assign frame_tick = frame_tick_q;
    assign hl_block   = hl_block_q;
    assign hl_price   = hl_price_q;
    assign hl_coin    = hl_coin_q;

endmodule

// File: tb/tb_disp_sel_ctrl.sv
// tb/tb_disp_sel_ctrl.sv - directed self-checking bench for disp_sel_ctrl
module tb_disp_sel_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [10:0] pixel_xpos, pixel_ypos;
    logic [5:0]  pix_area;
    logic        key_left, key_right, key_ok, key_cancel;
    logic [2:0]  coin_pulse;
    logic        vend_busy;
    logic [3:0]  cursor, sel_idx;
    logic        sel_valid, frame_tick, hl_block, hl_price, hl_coin;

    int checks = 0;
    int errors = 0;

    disp_sel_ctrl dut (
        .clk(clk), .rstn(rstn),
        .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .pix_area(pix_area),
        .key_left(key_left), .key_right(key_right), .key_ok(key_ok), .key_cancel(key_cancel),
        .coin_pulse(coin_pulse), .vend_busy(vend_busy),
        .cursor(cursor), .sel_valid(sel_valid), .sel_idx(sel_idx),
        .frame_tick(frame_tick), .hl_block(hl_block), .hl_price(hl_price), .hl_coin(hl_coin)
    );

    always #5 clk = ~clk;

    // All tasks start and end on a falling edge
    task automatic keys(input logic l, input logic r, input logic ok, input logic c);
        key_left = l; key_right = r; key_ok = ok; key_cancel = c;
        @(negedge clk);
        key_left = 0; key_right = 0; key_ok = 0; key_cancel = 0;
    endtask

    task automatic frame();
        pixel_xpos = 11'd799; pixel_ypos = 11'd479;
        @(negedge clk);
        pixel_xpos = 11'd0; pixel_ypos = 11'd0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic coin(input logic [2:0] c);
        coin_pulse = c;
        @(negedge clk);
        coin_pulse = 3'b000;
    endtask

    task automatic test_reset();
        rstn = 0; pixel_xpos = 0; pixel_ypos = 0; pix_area = 0;
        key_left = 0; key_right = 0; key_ok = 0; key_cancel = 0;
        coin_pulse = 0; vend_busy = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cursor, sel_idx, sel_valid, frame_tick, hl_block, hl_price, hl_coin} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {cursor, sel_idx, sel_valid, frame_tick, hl_block, hl_price, hl_coin});
        end
        rstn = 1;
        @(negedge clk);
    endtask

    task automatic test_cursor_wrap();
        logic [3:0] exp_c;
        for (int i = 1; i <= 13; i++) begin
            keys(0, 1, 0, 0);
            exp_c = 4'(i % 12);
            checks++;
            if (cursor !== exp_c) begin
                errors++;
                $display("FAIL cursor_right_%0d: got %0d expected %0d", i, cursor, exp_c);
            end
        end
        keys(1, 0, 0, 0);
        keys(1, 0, 0, 0);
        checks++;
        if (cursor !== 4'd11) begin
            errors++;
            $display("FAIL cursor_left_wrap: got %0d expected 11", cursor);
        end
        keys(1, 1, 0, 0);
        checks++;
        if (cursor !== 4'd11) begin
            errors++;
            $display("FAIL cursor_left_right: got %0d expected 11", cursor);
        end
    endtask

    task automatic test_blink();
        logic exp_b;
        repeat (4) keys(0, 1, 0, 0);
        pix_area = 6'd28;
        @(negedge clk);
        checks++;
        if (hl_block !== 1'b1) begin
            errors++;
            $display("FAIL blink_start: got %b expected 1", hl_block);
        end
        for (int k = 1; k <= 60; k++) begin
            frame();
            exp_b = ((k / 30) % 2) == 0;
            checks++;
            if (hl_block !== exp_b) begin
                errors++;
                $display("FAIL blink_frame_%0d: got %b expected %b", k, hl_block, exp_b);
            end
        end
        pix_area = 6'd27;
        @(negedge clk);
        checks++;
        if (hl_block !== 1'b0) begin
            errors++;
            $display("FAIL blink_other_block: got %b expected 0", hl_block);
        end
    endtask

    task automatic test_confirm();
        repeat (2) keys(0, 1, 0, 0);
        keys(0, 0, 1, 0);
        checks++;
        if (sel_valid !== 1'b1 || sel_idx !== 4'd5 || cursor !== 4'd5) begin
            errors++;
            $display("FAIL confirm_enter: got v=%b idx=%0d cur=%0d expected v=1 idx=5 cur=5", sel_valid, sel_idx, cursor);
        end
        pix_area = 6'd6;
        @(negedge clk);
        checks++;
        if (hl_price !== 1'b1) begin
            errors++;
            $display("FAIL confirm_price: got %b expected 1", hl_price);
        end
        pix_area = 6'd30;
        for (int k = 1; k <= 35; k++) begin
            frame();
            checks++;
            if (hl_block !== 1'b1) begin
                errors++;
                $display("FAIL confirm_steady_%0d: got %b expected 1", k, hl_block);
            end
        end
        keys(0, 1, 0, 0);
        checks++;
        if (cursor !== 4'd5) begin
            errors++;
            $display("FAIL confirm_frozen: got %0d expected 5", cursor);
        end
        keys(0, 0, 1, 1);
        checks++;
        if (sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL confirm_cancel_wins: got %b expected 0", sel_valid);
        end
        pix_area = 6'd6;
        @(negedge clk);
        checks++;
        if (hl_price !== 1'b0) begin
            errors++;
            $display("FAIL price_after_cancel: got %b expected 0", hl_price);
        end
        keys(0, 1, 0, 0);
        keys(1, 0, 1, 0);
        checks++;
        if (sel_valid !== 1'b1 || sel_idx !== 4'd6 || cursor !== 4'd6) begin
            errors++;
            $display("FAIL ok_with_move: got v=%b idx=%0d cur=%0d expected v=1 idx=6 cur=6", sel_valid, sel_idx, cursor);
        end
    endtask

    task automatic test_locked();
        vend_busy = 1;
        @(negedge clk);
        keys(0, 1, 0, 0);
        keys(0, 0, 0, 1);
        checks++;
        if (cursor !== 4'd6 || sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL locked_ignore: got cur=%0d v=%b expected cur=6 v=1", cursor, sel_valid);
        end
        vend_busy = 0;
        @(negedge clk);
        checks++;
        if (sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL locked_release: got %b expected 0", sel_valid);
        end
    endtask

    task automatic test_coin();
        pix_area = 6'd47;
        coin(3'b100);
        @(negedge clk);
        checks++;
        if (hl_coin !== 1'b1) begin
            errors++;
            $display("FAIL coin_start: got %b expected 1", hl_coin);
        end
        for (int k = 1; k <= 20; k++) begin
            frame();
            checks++;
            if (hl_coin !== (k < 20)) begin
                errors++;
                $display("FAIL coin_single_%0d: got %b expected %b", k, hl_coin, k < 20);
            end
        end
        coin(3'b100);
        for (int k = 1; k <= 30; k++) begin
            if (k == 11) coin(3'b100);
            frame();
            checks++;
            if (hl_coin !== (k < 30)) begin
                errors++;
                $display("FAIL coin_reload_%0d: got %b expected %b", k, hl_coin, k < 30);
            end
        end
        coin(3'b001);
        @(negedge clk);
        checks++;
        if (hl_coin !== 1'b0) begin
            errors++;
            $display("FAIL coin_other_frame: got %b expected 0", hl_coin);
        end
        pix_area = 6'd45;
        @(negedge clk);
        checks++;
        if (hl_coin !== 1'b1) begin
            errors++;
            $display("FAIL coin_bit0: got %b expected 1", hl_coin);
        end
    endtask

    task automatic test_frame_hold();
        int n = 0;
        pixel_xpos = 11'd799; pixel_ypos = 11'd479;
        repeat (5) begin
            @(negedge clk);
            n += int'(frame_tick);
        end
        pixel_xpos = 11'd0; pixel_ypos = 11'd0;
        repeat (2) begin
            @(negedge clk);
            n += int'(frame_tick);
        end
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL frame_hold_ticks: got %0d expected 1", n);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        keys(0, 0, 1, 0);
        repeat (5) frame();
        pix_area = 6'd31;
        @(negedge clk);
        checks++;
        if (hl_block !== 1'b1 || sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got hl=%b v=%b expected hl=1 v=1", hl_block, sel_valid);
        end
        pixel_xpos = 11'd799; pixel_ypos = 11'd479;
        rstn = 0;
        #1;
        checks++;
        if ({cursor, sel_idx, sel_valid, frame_tick, hl_block, hl_price, hl_coin} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 0", {cursor, sel_idx, sel_valid, frame_tick, hl_block, hl_price, hl_coin});
        end
        pix_area = 6'd25;
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        n += int'(frame_tick);
        checks++;
        if (hl_block !== 1'b1) begin
            errors++;
            $display("FAIL blink_on_after_reset: got %b expected 1", hl_block);
        end
        pix_area = 6'd45;
        @(negedge clk);
        n += int'(frame_tick);
        checks++;
        if (hl_coin !== 1'b0) begin
            errors++;
            $display("FAIL flash_after_reset: got %b expected 0", hl_coin);
        end
        @(negedge clk);
        n += int'(frame_tick);
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL tick_needs_fresh_match: got %0d expected 0", n);
        end
        pixel_xpos = 11'd0; pixel_ypos = 11'd0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_cursor_wrap();
        test_blink();
        test_confirm();
        test_locked();
        test_coin();
        test_frame_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
